// File: rtl/imem_loader_pkg.sv
// Shared state encoding, defaults and checksum helper for the instruction-memory
// boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_e;

  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;
  localparam int unsigned DEF_TIMEOUT   = 1024;

  // Running frame checksum: plain XOR of every byte after the sync marker.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input channel plus instruction-memory write port of the boot loader.
// The loader sits on the slave side; the stream source / memory wrapper on master.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a framed program image over a byte stream, writes it into
// instruction memory from address 0 and releases the CPU only after a clean checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [16:0]      DEPTH    = 17'd1 << ADDR_W;

  state_e            state_r;
  logic              in_ready_r;
  logic              we_r;
  logic              hold_r;
  logic              done_r;
  logic              error_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       wdata_r;
  logic [15:0]       len_r;
  logic [7:0]        hi_r;
  logic [7:0]        chk_r;
  logic [ADDR_W:0]   word_cnt_r;
  logic [TMR_W-1:0]  timer_r;

  logic              accept_s;
  logic [15:0]       len_s;
  logic [16:0]       next_cnt_s;

  assign accept_s   = bus.in_valid & in_ready_r;
  assign len_s      = {len_r[15:8], bus.in_data};
  // word_cnt is one bit wider than the address so a full-depth image is expressible.
  assign next_cnt_s = 17'(word_cnt_r) + 17'd1;

  // Frame FSM with registered handshake, write-port, hold and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 16'h0000;
      hold_r     <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      len_r      <= 16'h0000;
      hi_r       <= 8'h00;
      chk_r      <= 8'h00;
      word_cnt_r <= '0;
      timer_r    <= '0;
    end else begin
      we_r       <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      in_ready_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          timer_r <= '0;
          if (accept_s && (bus.in_data == SYNC_BYTE)) begin
            state_r    <= ST_LEN_HI;
            hold_r     <= 1'b1;
            chk_r      <= 8'h00;
            word_cnt_r <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: begin
          // An accepted byte always beats an expiring timer.
          if (accept_s) begin
            timer_r <= '0;
            case (state_r)
              ST_LEN_HI: begin
                len_r[15:8] <= bus.in_data;
                chk_r       <= chk_update(chk_r, bus.in_data);
                state_r     <= ST_LEN_LO;
              end
              ST_LEN_LO: begin
                len_r[7:0] <= bus.in_data;
                chk_r      <= chk_update(chk_r, bus.in_data);
                if ({1'b0, len_s} > DEPTH) begin
                  state_r    <= ST_ERR;
                  error_r    <= 1'b1;
                  in_ready_r <= 1'b0;
                end else if (len_s == 16'h0000) begin
                  state_r <= ST_CHECK;
                end else begin
                  state_r <= ST_DATA_HI;
                end
              end
              ST_DATA_HI: begin
                hi_r    <= bus.in_data;
                chk_r   <= chk_update(chk_r, bus.in_data);
                state_r <= ST_DATA_LO;
              end
              ST_DATA_LO: begin
                we_r       <= 1'b1;
                addr_r     <= word_cnt_r[ADDR_W-1:0];
                wdata_r    <= {hi_r, bus.in_data};
                chk_r      <= chk_update(chk_r, bus.in_data);
                word_cnt_r <= next_cnt_s[ADDR_W:0];
                if (next_cnt_s == {1'b0, len_r}) begin
                  state_r <= ST_CHECK;
                end else begin
                  state_r <= ST_DATA_HI;
                end
              end
              ST_CHECK: begin
                in_ready_r <= 1'b0;
                if (bus.in_data == chk_r) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
                  hold_r  <= 1'b0;
                end else begin
                  state_r <= ST_ERR;
                  error_r <= 1'b1;
                end
              end
              default: state_r <= ST_IDLE;
            endcase
          end else if (timer_r == TMR_LAST) begin
            state_r    <= ST_ERR;
            error_r    <= 1'b1;
            in_ready_r <= 1'b0;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        ST_DONE, ST_ERR: begin
          state_r <= ST_IDLE;
          timer_r <= '0;
        end
        default: begin
          state_r <= ST_IDLE;
          hold_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.imem_we    = we_r;
  assign bus.imem_addr  = addr_r;
  assign bus.imem_wdata = wdata_r;
  assign cpu_hold       = hold_r;
  assign busy           = (state_r != ST_IDLE);
  assign done           = done_r;
  assign error          = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed boot frames plus randomized frames compared
// against a byte-level frame parser that predicts writes, done/error and hold.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int         ADDR_W  = 8;
  localparam int         TIMEOUT = 1024;
  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [7:0] SYNC    = 8'hA5;

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic reset;
  logic cpu_hold, busy, done, error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          n_done = 0;
  int          n_err = 0;
  int          done0, err0, exp_done, exp_err;
  logic        exp_hold = 1'b1;
  logic [23:0] exp_wr [$];
  logic [23:0] obs_wr [$];

  // Records every write pulse and counts done/error pulse cycles.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) obs_wr.push_back({bus.imem_addr, bus.imem_wdata});
    if (done === 1'b1) n_done <= n_done + 1;
    if (error === 1'b1) n_err <= n_err + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Frame parser: skip to sync, read length, collect words, compare checksum.
  task automatic prep_frame(input bq_t b);
    int          i;
    logic [15:0] len;
    logic [7:0]  x;
    exp_wr.delete();
    obs_wr.delete();
    done0 = n_done;
    err0 = n_err;
    exp_done = 0;
    exp_err = 0;
    i = 0;
    while (i < b.size() && b[i] != SYNC) i++;
    if (i >= b.size()) return;
    exp_hold = 1'b1;
    len = {b[i+1], b[i+2]};
    x = b[i+1] ^ b[i+2];
    i += 3;
    if (int'(len) > DEPTH) begin
      exp_err = 1;
      return;
    end
    for (int k = 0; k < int'(len); k++) begin
      exp_wr.push_back({8'(k), b[i], b[i+1]});
      x = x ^ b[i] ^ b[i+1];
      i += 2;
    end
    if (b[i] == x) begin
      exp_done = 1;
      exp_hold = 1'b0;
    end else begin
      exp_err = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_data = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("ready_wait", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    repeat (4) @(negedge clk);
    check_eq({tag, "_nwr"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
      check_eq({tag, "_wr"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
    check_eq({tag, "_done"}, 32'(n_done - done0), 32'(exp_done));
    check_eq({tag, "_err"}, 32'(n_err - err0), 32'(exp_err));
    check_eq({tag, "_hold"}, 32'(cpu_hold), 32'(exp_hold));
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input bq_t b, input int max_gap, input int long_idx, input string tag);
    prep_frame(b);
    for (int i = 0; i < b.size(); i++)
      send_byte(b[i], (i == long_idx) ? TIMEOUT - 1 : int'($urandom_range(max_gap, 0)));
    finish_frame(tag);
  endtask

  task automatic build_frame(input int len, input bit corrupt, input int junk, output bq_t f);
    logic [7:0] x, v;
    f = {};
    for (int j = 0; j < junk; j++) begin
      v = 8'($urandom_range(255, 0));
      if (v == SYNC) v = 8'h00;
      f.push_back(v);
    end
    f.push_back(SYNC);
    f.push_back(8'(len >> 8));
    f.push_back(8'(len));
    x = 8'(len >> 8) ^ 8'(len);
    for (int k = 0; k < 2 * len; k++) begin
      v = 8'($urandom);
      f.push_back(v);
      x = x ^ v;
    end
    f.push_back(corrupt ? ~x : x);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t f;
    int  e0, n;

    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_we", 32'(bus.imem_we), 32'd0);
    check_eq("rst_addr", 32'(bus.imem_addr), 32'd0);
    check_eq("rst_wdata", 32'(bus.imem_wdata), 32'd0);
    check_eq("rst_hold", 32'(cpu_hold), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", 32'(bus.in_ready), 32'd1);

    // Good two-word frame with latency checks on the write and done pulses.
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    prep_frame(f);
    for (int i = 0; i < 7; i++) send_byte(f[i], 0);
    check_eq("t1_we", 32'(bus.imem_we), 32'd1);
    check_eq("t1_addr", 32'(bus.imem_addr), 32'd1);
    check_eq("t1_wdata", 32'(bus.imem_wdata), 32'h0000ABCD);
    send_byte(f[7], 0);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_hold", 32'(cpu_hold), 32'd0);
    check_eq("t1_ready_done", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check_eq("t1_done_pulse", 32'(done), 32'd0);
    finish_frame("t1");

    // Bad checksum: words still land, hold re-asserted at sync and kept.
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    prep_frame(f);
    send_byte(f[0], 0);
    check_eq("t2_hold_sync", 32'(cpu_hold), 32'd1);
    check_eq("t2_busy", 32'(busy), 32'd1);
    for (int i = 1; i < 8; i++) send_byte(f[i], 0);
    check_eq("t2_error", 32'(error), 32'd1);
    finish_frame("t2");

    run_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 0, -1, "t3");

    // Oversized length aborts right after LEN_LO.
    f = '{8'hA5, 8'h01, 8'h01};
    prep_frame(f);
    for (int i = 0; i < 3; i++) send_byte(f[i], 0);
    check_eq("t4_err_now", 32'(error), 32'd1);
    finish_frame("t4big");

    build_frame(DEPTH, 1'b0, 0, f);
    run_frame(f, 0, -1, "t4full");
    if (obs_wr.size() > 0) check_eq("t4_last_addr", 32'(obs_wr[$][23:16]), 32'd255);

    // Junk before sync, random short gaps and one gap just under the timeout.
    build_frame(3, 1'b0, 0, f);
    f.push_front(8'h5A);
    f.push_front(8'hFF);
    f.push_front(8'h00);
    run_frame(f, 5, 7, "t5");

    // Timeout after LEN_HI: error exactly TIMEOUT idle cycles later.
    obs_wr.delete();
    e0 = n_err;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    n = 0;
    while (error !== 1'b1 && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_timeout_cycles", 32'(n), 32'(TIMEOUT));
    repeat (3) @(negedge clk);
    check_eq("t5_timeout_err", 32'(n_err - e0), 32'd1);
    check_eq("t5_timeout_nwr", 32'(obs_wr.size()), 32'd0);
    check_eq("t5_timeout_hold", 32'(cpu_hold), 32'd1);

    // Reset mid-frame after the second word.
    obs_wr.delete();
    e0 = n_err;
    f = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 7; i++) send_byte(f[i], 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_we", 32'(bus.imem_we), 32'd0);
    check_eq("t6_addr", 32'(bus.imem_addr), 32'd0);
    check_eq("t6_wdata", 32'(bus.imem_wdata), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_hold", 32'(cpu_hold), 32'd1);
    check_eq("t6_ready", 32'(bus.in_ready), 32'd0);
    check_eq("t6_error", 32'(error), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_nwr", 32'(obs_wr.size()), 32'd2);
    check_eq("t6_no_err", 32'(n_err - e0), 32'd0);
    build_frame(4, 1'b0, 0, f);
    run_frame(f, 2, -1, "t6fresh");

    // Randomized frames.
    for (int r = 0; r < 20; r++) begin
      build_frame(int'($urandom_range(8, 0)), ($urandom_range(3, 0) == 0),
                  int'($urandom_range(3, 0)), f);
      run_frame(f, 3, -1, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
